// File: rtl/pp_accum_pkg.sv
// Shared constants and types for the partial-product accumulation sequencer.
package pp_accum_pkg;

    localparam int PP_SIZE  = 45;
    localparam int PP_RADIX = 108;
    localparam int PP_N_PP  = 24;
    localparam int PP_GROUP = 5;

    localparam logic [2:0] GRP_LAST = 3'd4;

    // Left-shift applied to each partial product before it joins the sum.
    localparam int SHIFT_TAB [PP_N_PP] = '{
          0,  18,  36,  54,  72,  90,
         27,  45,  63,  81,  99, 117,
         54,  72,  90, 108, 126, 144,
         81,  99, 117, 135, 153, 171
    };

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    typedef enum logic [0:0] {
        ACC  = ST_ACC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/pp_shift_sum5.sv
// Combinational shift-and-add of one beat of partial products onto the accumulator.
module pp_shift_sum5
    import pp_accum_pkg::*;
#(
    parameter int SIZE  = PP_SIZE,
    parameter int RADIX = PP_RADIX,
    parameter int N_PP  = PP_N_PP,
    parameter int GROUP = PP_GROUP
) (
    input  logic [2:0]            grp,
    input  logic [GROUP*SIZE-1:0] lanes,
    input  logic [2*RADIX-1:0]    acc_in,
    output logic [2*RADIX-1:0]    sum
);

    localparam int W = 2 * RADIX;

    logic [SIZE-1:0] lane_val [GROUP];
    logic [4:0]      pp_idx   [GROUP];
    logic [W-1:0]    term     [GROUP];

    // Align each lane to its weight; the last group has one lane fewer, so its top lane is zeroed.
    always_comb begin
        for (int k = 0; k < GROUP; k++) begin
            lane_val[k] = lanes[k*SIZE +: SIZE];
            pp_idx[k]   = 5'(int'(grp) * GROUP + k);
            term[k]     = '0;
            if (!((grp == GRP_LAST) && (k == GROUP - 1)) && (int'(pp_idx[k]) < N_PP)) begin
                term[k] = W'(lane_val[k]) << SHIFT_TAB[pp_idx[k]];
            end
        end
    end

    // Single wide add of the accumulator and all aligned lanes; overflow past the top bit wraps.
    always_comb begin
        sum = acc_in;
        for (int k = 0; k < GROUP; k++) begin
            sum = sum + term[k];
        end
    end

endmodule

// File: rtl/pp_accum_sched.sv
// Time-shared accumulator that folds 24 partial products into a 216-bit product over five beats.
module pp_accum_sched
    import pp_accum_pkg::*;
#(
    parameter int SIZE  = PP_SIZE,
    parameter int RADIX = PP_RADIX,
    parameter int N_PP  = PP_N_PP,
    parameter int GROUP = PP_GROUP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [GROUP*SIZE-1:0] in_pp,
    output logic [2*RADIX-1:0]    res,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int W = 2 * RADIX;

    state_t       state;
    logic [2:0]   grp;
    logic [W-1:0] acc;
    logic [W-1:0] acc_base;
    logic [W-1:0] acc_next;

    // The first beat of a product starts from zero, so a finished result never needs an explicit clear cycle.
    always_comb begin
        acc_base = (grp == 3'd0) ? '0 : acc;
    end

    pp_shift_sum5 #(
        .SIZE  (SIZE),
        .RADIX (RADIX),
        .N_PP  (N_PP),
        .GROUP (GROUP)
    ) u_sum (
        .grp    (grp),
        .lanes  (in_pp),
        .acc_in (acc_base),
        .sum    (acc_next)
    );

    // Sequencer: accept beats in ACC, present the product in DONE until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            grp   <= 3'd0;
            acc   <= '0;
        end else if (clear) begin
            state <= ACC;
            grp   <= 3'd0;
            acc   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        if (grp == GRP_LAST) begin
                            grp   <= 3'd0;
                            state <= DONE;
                        end else begin
                            grp <= grp + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                    grp   <= 3'd0;
                end
            endcase
        end
    end

    // Handshake and status outputs decode directly from the registered state.
    always_comb begin
        in_ready  = (state == ACC);
        res_valid = (state == DONE);
        res       = acc;
        busy      = ((state == ACC) && (grp != 3'd0)) || (state == DONE);
    end

endmodule

// File: tb/tb_pp_accum_sched.sv
// Self-checking bench for pp_accum_sched: directed table, multi-cycle corner cases, random products.
module tb_pp_accum_sched;

    localparam int SIZE  = 45;
    localparam int RADIX = 108;
    localparam int N_PP  = 24;
    localparam int GROUP = 5;
    localparam int W     = 2 * RADIX;
    localparam int PPW   = N_PP * SIZE;

    logic                  clk;
    logic                  rst_n;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [GROUP*SIZE-1:0] in_pp;
    logic [W-1:0]          res;
    logic                  res_valid;
    logic                  res_ready;
    logic                  busy;

    int pass_count;
    int check_count;

    typedef struct {
        string          name;
        logic [PPW-1:0] pps;
        logic [SIZE-1:0] extra;
        logic [W-1:0]   expected;
    } vec_t;

    vec_t vecs [7];

    pp_accum_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pp     (in_pp),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Partial products sit on a grid: row r = i/6 adds 27*r, column c = i%6 adds 18*c.
    function automatic int weight_of(int i);
        return 27 * (i / 6) + 18 * (i % 6);
    endfunction

    // Reference: plain weighted sum of all 24 partial products, truncated to the result width.
    function automatic logic [W-1:0] ref_product(logic [PPW-1:0] pps);
        logic [W-1:0] total;
        total = '0;
        for (int i = 0; i < N_PP; i++) begin
            total = total + (W'(pps[i*SIZE +: SIZE]) << weight_of(i));
        end
        return total;
    endfunction

    function automatic logic [PPW-1:0] pp_one(int i);
        logic [PPW-1:0] v;
        v = '0;
        v[i*SIZE] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [W-1:0] actual, logic [W-1:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive beats 0..nbeats-1 of a product, optionally with random idle cycles between beats.
    task automatic send_beats(logic [PPW-1:0] pps, logic [SIZE-1:0] extra, int nbeats, bit gaps);
        for (int g = 0; g < nbeats; g++) begin
            if (gaps) begin
                int idle;
                idle = int'($urandom_range(0, 2));
                for (int j = 0; j < idle; j++) begin
                    in_valid = 1'b0;
                    in_pp    = GROUP*SIZE'($urandom());
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("in_ready_beat", W'(in_ready), W'(1));
            for (int k = 0; k < GROUP; k++) begin
                if (g * GROUP + k < N_PP) begin
                    in_pp[k*SIZE +: SIZE] = pps[(g*GROUP+k)*SIZE +: SIZE];
                end else begin
                    in_pp[k*SIZE +: SIZE] = extra;
                end
            end
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("res_valid_after_take", W'(res_valid), W'(0));
        checkOutput("in_ready_after_take", W'(in_ready), W'(1));
    endtask

    // Full product: five beats, result must be valid the cycle after the last beat, then consumed.
    task automatic applyStimulus(string name, logic [PPW-1:0] pps, logic [SIZE-1:0] extra,
                                 logic [W-1:0] expected, bit gaps);
        send_beats(pps, extra, 5, gaps);
        checkOutput({name, "_res_valid"}, W'(res_valid), W'(1));
        checkOutput({name, "_res"}, res, expected);
        take_result();
    endtask

    initial begin
        logic [PPW-1:0] pps;
        logic [W-1:0]   exp_val;

        pass_count  = 0;
        check_count = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_pp     = '0;
        res_ready = 1'b0;

        vecs[0] = '{"pp0",        pp_one(0),              '0, W'(1)};
        vecs[1] = '{"pp23",       pp_one(23),             '0, W'(1) << 171};
        vecs[2] = '{"g4_lane4",   '0,                     '1, W'(0)};
        vecs[3] = '{"pp3_pp12",   pp_one(3) | pp_one(12), '0, W'(1) << 55};
        vecs[4] = '{"pp1",        pp_one(1),              '0, W'(1) << 18};
        vecs[5] = '{"pp6",        pp_one(6),              '0, W'(1) << 27};
        vecs[6] = '{"pp17",       pp_one(17),             '0, W'(1) << 144};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_res", res, W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_res", res, W'(0));
        checkOutput("reset_res_valid", W'(res_valid), W'(0));
        checkOutput("reset_in_ready", W'(in_ready), W'(1));
        checkOutput("reset_busy", W'(busy), W'(0));

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].name, vecs[v].pps, vecs[v].extra, vecs[v].expected, 1'b0);
        end

        // Consumer stall: result and status must hold while res_ready stays low.
        pps = '0;
        for (int i = 0; i < N_PP; i++) pps[i*SIZE +: SIZE] = SIZE'({$urandom(), $urandom()});
        exp_val = ref_product(pps);
        send_beats(pps, '0, 5, 1'b0);
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall_res", res, exp_val);
            checkOutput("stall_in_ready", W'(in_ready), W'(0));
            checkOutput("stall_busy", W'(busy), W'(1));
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        checkOutput("handshake_in_ready", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("post_stall_res_valid", W'(res_valid), W'(0));
        checkOutput("post_stall_busy", W'(busy), W'(0));
        applyStimulus("zero_after_stall", '0, '0, W'(0), 1'b0);

        // Abort mid-product: clear wins over a simultaneous beat.
        send_beats(pp_one(0), '0, 2, 1'b0);
        checkOutput("pre_clear_busy", W'(busy), W'(1));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_pp    = '1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear_busy", W'(busy), W'(0));
        checkOutput("clear_res", res, W'(0));
        checkOutput("clear_in_ready", W'(in_ready), W'(1));
        applyStimulus("pp0_after_clear", pp_one(0), '0, W'(1), 1'b0);

        // Asynchronous reset mid-product discards everything immediately.
        pps = '0;
        for (int i = 0; i < N_PP; i++) pps[i*SIZE +: SIZE] = SIZE'({$urandom(), $urandom()});
        send_beats(pps, '0, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_res", res, W'(0));
        checkOutput("async_rst_res_valid", W'(res_valid), W'(0));
        checkOutput("async_rst_in_ready", W'(in_ready), W'(1));
        checkOutput("async_rst_busy", W'(busy), W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        pps = '1;
        applyStimulus("all_ones_wrap", pps, '1, ref_product(pps), 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [SIZE-1:0] extra;
            pps = '0;
            for (int i = 0; i < N_PP; i++) pps[i*SIZE +: SIZE] = SIZE'({$urandom(), $urandom()});
            extra = SIZE'({$urandom(), $urandom()});
            applyStimulus("random", pps, extra, ref_product(pps), 1'b1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pp_accum_sched.md
# pp_accum_sched

Multi-cycle sequencer for the 108-bit radix multiplier's partial-product reduction. It accepts the 24 partial products (45 bits each) as five beats of up to five operands. Each beat goes through one shared five-operand 216-bit adder, and the block accumulates the full 216-bit product in a register. It sits between the partial-product generator and the final product consumer, and replaces five parallel 5-input adders with one adder that is time-shared across groups.

## Interface
Parameters:
- SIZE, 45, partial-product width
- RADIX, 108, operand radix; the result is 2*RADIX bits
- N_PP, 24, partial products per multiplication
- GROUP, 5, operands per beat (adder fan-in)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort; highest priority after reset
- in_valid  input  1  beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_pp  input  GROUP*SIZE  lane k = in_pp[k*SIZE +: SIZE] = partial product 5*grp+k
- res  output  2*RADIX  final product, driven from the accumulator register
- res_valid  output  1  res holds a completed product
- res_ready  input  1  consumer accepts res
- busy  output  1  at least one beat accepted and result not yet taken

## Operation
- Shift table, indexed by partial product 0..23: 0,18,36,54,72,90, 27,45,63,81,99,117, 54,72,90,108,126,144, 81,99,117,135,153,171.
- Per accepted beat, acc_next = acc + sum over k of ({171'b0, lane k} << shift[5*grp+k]).
  - Addition is modulo 2^216; carries out of bit 215 are discarded.
  - On the grp==0 beat, acc is treated as 0, so no separate clear cycle is needed.
- Group 4 carries only pp 20..23. Lane 4 of that beat is ignored and forced to zero, whatever its value.
- States:
  - ACC: in_ready=1, res_valid=0. The beat handshake (in_valid&in_ready) updates acc. grp increments 0→4; the grp==4 beat moves to DONE and grp resets to 0.
  - DONE: in_ready=0, res_valid=1, res=acc held stable. The res handshake (res_valid&res_ready) moves to ACC.
- busy = (state==ACC && grp!=0) || state==DONE.
- clear = 1 in any state, regardless of other inputs: next state ACC, grp=0, acc=0, res_valid=0. A beat presented in the same cycle is dropped.
- in_valid low in ACC: no state change; acc and grp hold.
- res_ready is ignored outside DONE.

## Timing
- Reset values: state=ACC, grp=0, acc=0. Resulting outputs: res=0, res_valid=0, in_ready=1, busy=0.
- Reset asserts asynchronously. Asserting rst_n low mid-operation discards all progress.
- A beat accepted at edge t is reflected in acc after edge t.
- Final-beat latency: the beat accepted at edge t gives res_valid=1 in cycle t+1.
- in_ready is low throughout DONE, including the res handshake cycle. The next beat is accepted at the earliest one cycle after the res handshake.
- Minimum interval: 6 cycles per product (5 beats + 1 result cycle).
- Adder path: one 216-bit, 6-operand add (acc plus 5 lanes) per cycle, with no pipelining inside the block.

## Structure
- Package pp_accum_pkg holds:
  - SIZE, RADIX, N_PP, GROUP defaults
  - the 24-entry shift constant array
  - state enum {ACC, DONE}
  - GRP_LAST=4
- Sub-module pp_shift_sum5: purely combinational.
  - Inputs: grp, five lanes, acc_in.
  - Applies the table shifts and lane-4 masking for grp==4.
  - Returns the 216-bit sum.
- The top level holds the FSM, the grp counter, the acc register and the handshakes.

## Test plan
- Only pp0=1, all other lanes 0 over five beats → res=1; res_valid rises one cycle after the fifth beat is accepted.
- Only pp23=1 (group 4, lane 3) → res=2^171. Group 4 lane 4 set to all ones with everything else zero → res=0 (lane ignored).
- pp3=1 and pp12=1, both at shift 54 → res=2^55, which checks accumulation across groups with colliding shifts.
- res_ready held low for 10 cycles in DONE → res stable, in_ready=0, busy=1; then release it → back to ACC, and the next product (all lanes 0) gives res=0.
- Two beats accepted, then clear=1 together with in_valid=1 → grp=0, acc=0, busy=0, beat dropped; a following pp0=1 product gives res=1.
- rst_n pulsed low mid-operation (after 3 beats) → all outputs immediately at reset values; a following random full product matches the golden model's modulo-2^216 sum over 20 random vectors.
